// File: rtl/dataflow_profiler.sv
// Per-channel ap_ctrl handshake profiler: transaction, busy, stall and max-latency counters with registered readout.
// Define DATAFLOW_PROFILER_MAXLAT_EN to build in the per-channel latency tracker and max_latency register.
module dataflow_profiler #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_continue,
    input  logic              finish,
    input  logic              rd_req,
    input  logic [3:0]        rd_sel,
    input  logic [1:0]        rd_field,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] overflow,
    output logic              profiling_done
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT_CONT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] txn_q   [NUM_CH];
    logic [CNT_W-1:0] txn_d   [NUM_CH];
    logic [CNT_W-1:0] busy_q  [NUM_CH];
    logic [CNT_W-1:0] busy_d  [NUM_CH];
    logic [CNT_W-1:0] stall_q [NUM_CH];
    logic [CNT_W-1:0] stall_d [NUM_CH];
`ifdef DATAFLOW_PROFILER_MAXLAT_EN
    logic [CNT_W-1:0] lat_q    [NUM_CH];
    logic [CNT_W-1:0] lat_d    [NUM_CH];
    logic [CNT_W-1:0] maxlat_q [NUM_CH];
    logic [CNT_W-1:0] maxlat_d [NUM_CH];
`endif
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic              frozen;

    always_comb begin : ch_next
        logic active;
        logic inc_txn;
        logic inc_stall;
`ifdef DATAFLOW_PROFILER_MAXLAT_EN
        logic [CNT_W-1:0] cur_lat;
        cur_lat  = '0;
        lat_d    = lat_q;
        maxlat_d = maxlat_q;
`endif
        active    = 1'b0;
        inc_txn   = 1'b0;
        inc_stall = 1'b0;
        frozen    = finish | done_q;
        state_d   = state_q;
        txn_d     = txn_q;
        busy_d    = busy_q;
        stall_d   = stall_q;
        ovf_d     = ovf_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            active    = 1'b0;
            inc_txn   = 1'b0;
            inc_stall = 1'b0;
            if (!frozen) begin
                case (state_q[i])
                    S_IDLE: if (ch_start[i]) begin
                        active = 1'b1;
                        if (!ch_done[i])         state_d[i] = S_BUSY;
                        else if (ch_continue[i]) inc_txn    = 1'b1;
                        else                     state_d[i] = S_WAIT_CONT;
                    end
                    // A completion that coincides with ch_start hands straight over to the next transaction.
                    S_BUSY: begin
                        active = 1'b1;
                        if (ch_done[i]) begin
                            if (ch_continue[i]) begin
                                inc_txn = 1'b1;
                                if (!ch_start[i]) state_d[i] = S_IDLE;
                            end else begin
                                state_d[i] = S_WAIT_CONT;
                            end
                        end
                    end
                    S_WAIT_CONT: begin
                        if (ch_continue[i]) begin
                            inc_txn    = 1'b1;
                            state_d[i] = S_IDLE;
                        end else begin
                            inc_stall = 1'b1;
                        end
                    end
                    default: state_d[i] = S_IDLE;
                endcase
            end

            if (inc_txn) begin
                if (txn_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                else                     txn_d[i] = txn_q[i] + CNT_W'(1);
            end
            if (active) begin
                if (busy_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                else                      busy_d[i] = busy_q[i] + CNT_W'(1);
            end
            if (inc_stall) begin
                if (stall_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                else                       stall_d[i] = stall_q[i] + CNT_W'(1);
            end

`ifdef DATAFLOW_PROFILER_MAXLAT_EN
            // lat_q holds the cycles already spent; the current cycle is one more.
            if (state_q[i] == S_IDLE) begin
                cur_lat = CNT_W'(1);
            end else if (lat_q[i] == CNT_MAX) begin
                cur_lat = CNT_MAX;
                if (active) ovf_d[i] = 1'b1;
            end else begin
                cur_lat = lat_q[i] + CNT_W'(1);
            end
            if (active) begin
                lat_d[i] = (state_q[i] == S_BUSY && ch_done[i] && ch_continue[i] && ch_start[i])
                           ? CNT_W'(1) : cur_lat;
                if (ch_done[i] && cur_lat > maxlat_q[i]) maxlat_d[i] = cur_lat;
            end
`endif
        end
    end

    always_comb begin : rd_next
        rd_valid_d = rd_req;
        done_d     = done_q | finish;
        rd_data_d  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_req && rd_sel == 4'(i)) begin
                case (rd_field)
                    2'd0:    rd_data_d = txn_q[i];
                    2'd1:    rd_data_d = busy_q[i];
                    2'd2:    rd_data_d = stall_q[i];
                    default: begin
`ifdef DATAFLOW_PROFILER_MAXLAT_EN
                        rd_data_d = maxlat_q[i];
`else
                        rd_data_d = '0;
`endif
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= S_IDLE;
                txn_q[i]    <= '0;
                busy_q[i]   <= '0;
                stall_q[i]  <= '0;
`ifdef DATAFLOW_PROFILER_MAXLAT_EN
                lat_q[i]    <= '0;
                maxlat_q[i] <= '0;
`endif
            end
            ovf_q      <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            busy_q     <= busy_d;
            stall_q    <= stall_d;
`ifdef DATAFLOW_PROFILER_MAXLAT_EN
            lat_q      <= lat_d;
            maxlat_q   <= maxlat_d;
`endif
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign overflow       = ovf_q;
    assign profiling_done = done_q;

endmodule

// File: tb/tb_dataflow_profiler.sv
// Bench for dataflow_profiler: transaction-level model checked every cycle plus literal readouts.
module tb_dataflow_profiler;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int MAXV = 255;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  ch_start = '0;
    logic [NCH-1:0]  ch_done = '0;
    logic [NCH-1:0]  ch_continue = '1;
    logic            finish = 1'b0;
    logic            rd_req = 1'b0;
    logic [3:0]      rd_sel = '0;
    logic [1:0]      rd_field = '0;
    logic            rd_valid;
    logic [CW-1:0]   rd_data;
    logic [NCH-1:0]  overflow;
    logic            profiling_done;

    int errors = 0;
    int checks = 0;

    dataflow_profiler #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .ch_start(ch_start), .ch_done(ch_done), .ch_continue(ch_continue),
        .finish(finish), .rd_req(rd_req), .rd_sel(rd_sel), .rd_field(rd_field),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .overflow(overflow), .profiling_done(profiling_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: unbounded per-channel totals; the DUT view saturates them.
    int m_txn[NCH], m_busy[NCH], m_stall[NCH], m_maxl[NCH], m_lat[NCH];
    bit m_open[NCH], m_wait[NCH];
    bit m_frozen = 1'b0;
    bit m_valid = 1'b0;
    bit m_live = 1'b0;
    logic [CW-1:0]  m_data = '0;
    logic [NCH-1:0] m_ovf;

    function automatic int sat(input int n);
        return (n > MAXV) ? MAXV : n;
    endfunction

    function automatic int lat_view(input int n);
`ifdef DATAFLOW_PROFILER_MAXLAT_EN
        return sat(n);
`else
        return 0 * n;
`endif
    endfunction

    function automatic int model_read(input logic [3:0] sel, input logic [1:0] f);
        int idx;
        idx = int'(sel);
        if (idx >= NCH) return 0;
        case (f)
            2'd0:    return sat(m_txn[idx]);
            2'd1:    return sat(m_busy[idx]);
            2'd2:    return sat(m_stall[idx]);
            default: return lat_view(m_maxl[idx]);
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_txn[c] = 0; m_busy[c] = 0; m_stall[c] = 0; m_maxl[c] = 0; m_lat[c] = 0;
                m_open[c] = 1'b0; m_wait[c] = 1'b0;
            end
            m_frozen = 1'b0;
            m_valid  = 1'b0;
            m_data   = '0;
            m_live   = 1'b1;
        end else begin
            m_valid = rd_req;
            m_data  = CW'(model_read(rd_sel, rd_field));
            if (!m_frozen && !finish) begin
                for (int c = 0; c < NCH; c++) begin
                    if (m_wait[c]) begin
                        if (ch_continue[c]) begin m_txn[c]++; m_wait[c] = 1'b0; end
                        else m_stall[c]++;
                    end else if (m_open[c] || ch_start[c]) begin
                        m_lat[c] = m_open[c] ? m_lat[c] + 1 : 1;
                        m_busy[c]++;
                        if (ch_done[c]) begin
                            if (m_lat[c] > m_maxl[c]) m_maxl[c] = m_lat[c];
                            if (!ch_continue[c]) begin
                                m_open[c] = 1'b0;
                                m_wait[c] = 1'b1;
                            end else begin
                                m_txn[c]++;
                                if (m_open[c] && ch_start[c]) m_lat[c] = 1;
                                else m_open[c] = 1'b0;
                            end
                        end else begin
                            m_open[c] = 1'b1;
                        end
                    end
                end
            end
            if (finish) m_frozen = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            for (int c = 0; c < NCH; c++)
                m_ovf[c] = (m_txn[c] > MAXV) || (m_busy[c] > MAXV) || (m_stall[c] > MAXV);
            chk("cyc rd_valid", 32'(rd_valid), 32'(m_valid));
            if (m_valid) chk("cyc rd_data", 32'(rd_data), 32'(m_data));
            chk("cyc overflow", 32'(overflow), 32'(m_ovf));
            chk("cyc profiling_done", 32'(profiling_done), 32'(m_frozen));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic read_expect(input string name, input logic [3:0] sel, input logic [1:0] f,
                               input int exp);
        rd_req = 1'b1; rd_sel = sel; rd_field = f;
        tick();
        rd_req = 1'b0;
        chk({name, " valid"}, 32'(rd_valid), 32'd1);
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick(2);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset profiling_done", 32'(profiling_done), 32'd0);
        reset = 1'b0;
        tick(5);

        // ch0: five-cycle transaction
        ch_start[0] = 1'b1; tick(); ch_start[0] = 1'b0;
        tick(3);
        ch_done[0] = 1'b1; tick(); ch_done[0] = 1'b0;
        tick();
        read_expect("ch0 txn", 4'd0, 2'd0, 1);
        read_expect("ch0 busy", 4'd0, 2'd1, 5);
        read_expect("ch0 stall", 4'd0, 2'd2, 0);
        read_expect("ch0 maxlat", 4'd0, 2'd3, lat_view(5));

        // ch1: done with continue low, three stall cycles, read races the continue
        ch_start[1] = 1'b1; tick(); ch_start[1] = 1'b0;
        tick(2);
        ch_done[1] = 1'b1; ch_continue[1] = 1'b0; tick(); ch_done[1] = 1'b0;
        tick(3);
        ch_continue[1] = 1'b1; rd_req = 1'b1; rd_sel = 4'd1; rd_field = 2'd0;
        tick(); rd_req = 1'b0;
        chk("ch1 txn before continue", 32'(rd_data), 32'd0);
        read_expect("ch1 txn", 4'd1, 2'd0, 1);
        read_expect("ch1 stall", 4'd1, 2'd2, 3);
        read_expect("ch1 busy", 4'd1, 2'd1, 4);
        read_expect("ch1 maxlat", 4'd1, 2'd3, lat_view(4));

        // ch2: three back-to-back completions, then a final one
        ch_start[2] = 1'b1; tick(); ch_start[2] = 1'b0;
        tick();
        repeat (3) begin
            ch_start[2] = 1'b1; ch_done[2] = 1'b1; tick();
            ch_start[2] = 1'b0; ch_done[2] = 1'b0; tick();
        end
        read_expect("ch2 txn after overlaps", 4'd2, 2'd0, 3);
        ch_done[2] = 1'b1; tick(); ch_done[2] = 1'b0;
        read_expect("ch2 txn", 4'd2, 2'd0, 4);
        read_expect("ch2 busy", 4'd2, 2'd1, 10);
        read_expect("ch2 maxlat", 4'd2, 2'd3, lat_view(4));

        // ch3: saturation
        chk("overflow clear", 32'(overflow), 32'd0);
        ch_start[3] = 1'b1; ch_done[3] = 1'b1; tick(300);
        ch_start[3] = 1'b0; ch_done[3] = 1'b0; tick();
        chk("overflow ch3", 32'(overflow), 32'h8);
        read_expect("ch3 txn sat", 4'd3, 2'd0, 255);
        read_expect("ch3 busy sat", 4'd3, 2'd1, 255);
        read_expect("ch3 maxlat", 4'd3, 2'd3, lat_view(1));

        // finish mid-transaction on ch0
        ch_start[0] = 1'b1; tick(); ch_start[0] = 1'b0;
        tick();
        finish = 1'b1; ch_done[0] = 1'b1; tick(); finish = 1'b0;
        chk("profiling_done", 32'(profiling_done), 32'd1);
        ch_start[1] = 1'b1; tick(3);
        ch_done[0] = 1'b0; ch_start[1] = 1'b0; tick(2);
        read_expect("frozen ch0 txn", 4'd0, 2'd0, 1);
        read_expect("frozen ch0 busy", 4'd0, 2'd1, 7);
        read_expect("frozen ch1 busy", 4'd1, 2'd1, 4);
        read_expect("frozen ch3 txn", 4'd3, 2'd0, 255);
        read_expect("sel4 out of range", 4'd4, 2'd1, 0);
        chk("frozen overflow", 32'(overflow), 32'h8);

        // reset priority, reset mid-transaction, idle done ignored
        rd_req = 1'b1; rd_sel = 4'd3; rd_field = 2'd0; reset = 1'b1;
        tick(); rd_req = 1'b0;
        chk("reset beats rd_req", 32'(rd_valid), 32'd0);
        chk("reset clears done", 32'(profiling_done), 32'd0);
        chk("reset clears overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        ch_start[0] = 1'b1; tick(); ch_start[0] = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        ch_done[0] = 1'b1; tick(); ch_done[0] = 1'b0;
        read_expect("post-reset ch0 txn", 4'd0, 2'd0, 0);
        read_expect("post-reset ch0 busy", 4'd0, 2'd1, 0);
        read_expect("post-reset ch0 maxlat", 4'd0, 2'd3, 0);
        read_expect("sel7 out of range", 4'd7, 2'd0, 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dataflow_profiler.md
DATAFLOW_PROFILER -- requirements
Module: dataflow_profiler

Interface
REQ-001 Parameter NUM_CH, default 4: number of monitored ap_ctrl channels, 1..16.
REQ-002 Parameter CNT_W, default 32: width of every statistics counter, 8..48.
REQ-003 Port clock  in  1: single clock; all logic rising-edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port ch_start  in  NUM_CH: per-channel ap_start.
REQ-006 Port ch_done  in  NUM_CH: per-channel ap_done.
REQ-007 Port ch_continue  in  NUM_CH: per-channel ap_continue; tie 1 for non-dataflow channels.
REQ-008 Port finish  in  1: end-of-run; freezes all statistics.
REQ-009 Port rd_req  in  1: readout request.
REQ-010 Port rd_sel  in  4: channel index.
REQ-011 Port rd_field  in  2: 0=txn_count, 1=busy_cycles, 2=stall_cycles, 3=max_latency.
REQ-012 Port rd_valid  out  1: rd_data valid.
REQ-013 Port rd_data  out  CNT_W: selected counter.
REQ-014 Port overflow  out  NUM_CH: sticky per-channel saturation flag.
REQ-015 Port profiling_done  out  1: statistics frozen.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE, BUSY and WAIT_CONT.
REQ-017 IDLE: ch_start=1 SHALL start a transaction; that cycle is latency cycle 1; next state BUSY, unless done is also high that cycle.
REQ-018 BUSY or start cycle with ch_done=1 and ch_continue=1 SHALL increment txn_count and record latency; next state IDLE.
REQ-019 ch_done=1 with ch_continue=0 SHALL record latency; next state WAIT_CONT.
REQ-020 WAIT_CONT: each cycle with ch_continue=0 SHALL increment stall_cycles; ch_continue=1 SHALL increment txn_count, next state IDLE.
REQ-021 Back-to-back: a completion in BUSY with ch_start=1 in the same cycle SHALL start a new transaction; state stays BUSY, latency restarts at 1.
REQ-022 busy_cycles SHALL increment on every cycle counted toward a transaction's latency.
REQ-023 ch_done in IDLE without ch_start SHALL be ignored.
REQ-024 Counters SHALL saturate at all-ones and set overflow[ch], which holds until reset.
REQ-025 max_latency SHALL keep the largest recorded latency.
REQ-026 finish=1 SHALL freeze all counters and FSMs from the next edge; profiling_done=1 one cycle after finish is sampled; frozen until reset.
REQ-027 rd_req=1 SHALL produce rd_valid=1 and rd_data on the next cycle; rd_valid=0 otherwise; readout allowed before and after finish.
REQ-028 rd_sel >= NUM_CH SHALL return rd_data=0 with rd_valid=1.
REQ-029 A counter update and a read of that counter in the same cycle SHALL return the pre-update value.

Reset
REQ-030 reset SHALL force all FSMs to IDLE and clear counters, overflow, rd_valid, rd_data and profiling_done to 0.
REQ-031 reset mid-transaction SHALL discard the partial latency; the channel is not counted.
REQ-032 reset SHALL take priority over finish, rd_req and every channel event.

Configuration
REQ-033 Macro DATAFLOW_PROFILER_MAXLAT_EN defined: per-channel latency counter and max_latency register compiled in.
REQ-034 Macro undefined: latency logic removed; rd_field=3 reads 0; all other behaviour identical.

Verification
REQ-035 Ch0 start at cycle 10, done+continue at cycle 14 -> txn_count=1, busy_cycles=5, max_latency=5, stall_cycles=0.
REQ-036 Ch1 done at cycle 20 with continue=0 for 3 cycles, then 1 -> stall_cycles=3, txn_count=1 only after continue rises.
REQ-037 Ch2 done+continue and start in the same cycle, 3 times -> txn_count=3, FSM never visits IDLE between them.
REQ-038 CNT_W=8, 300 single-cycle transactions on ch3 -> txn_count=255, overflow[3]=1 until reset.
REQ-039 finish pulse mid-transaction, then further events -> counters unchanged, profiling_done=1 next cycle, reads still valid.
REQ-040 reset during BUSY, then rd_sel=0, rd_field=0 read -> rd_data=0; rd_sel=7 with NUM_CH=4 -> rd_data=0, rd_valid=1.
